reg_file_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the 4 x 8-bit register file. It lets two requesters, port 0 (core datapath) and port 1 (debug/loader), share the single address/CE/data port. It serializes their read and write transactions with round-robin fairness, drives the register file's ADDR/CE/DATA_IN, and captures the file's one-cycle-latency DATA_OUT into a per-port response.

---
 rtl/reg_file_arbiter_pkg.sv | 21 ++
 rtl/reg_file_arbiter_if.sv | 28 ++
 rtl/reg_file_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/reg_file_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_file_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and constants for the two-port register-file arbiter.
// Holds the FSM state encoding and the address-to-CE decode helper.
package reg_file_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int NUM_REGS  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // One-hot register enable for a given register address.
  function automatic logic [NUM_REGS-1:0] onehot_addr(input logic [ADDR_W-1:0] addr);
    onehot_addr = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Requester-side bus of the register-file arbiter: both ports' commands and responses.
// The arbiter uses the slave modport, the requesters the master modport.
interface reg_file_arbiter_if;
  import reg_file_arb_pkg::*;

  logic [NUM_PORTS-1:0] REQ;
  logic [NUM_PORTS-1:0] WE;
  logic [ADDR_W-1:0]    ADDR0;
  logic [ADDR_W-1:0]    ADDR1;
  logic [DATA_W-1:0]    WDATA0;
  logic [DATA_W-1:0]    WDATA1;
  logic [NUM_PORTS-1:0] GNT;
  logic [NUM_PORTS-1:0] DONE;
  logic [DATA_W-1:0]    RDATA0;
  logic [DATA_W-1:0]    RDATA1;
  logic                 BUSY;

  modport master (
    output REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1,
    input  GNT, DONE, RDATA0, RDATA1, BUSY
  );

  modport slave (
    input  REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1,
    output GNT, DONE, RDATA0, RDATA1, BUSY
  );

endinterface

// File: rtl/reg_file_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the caller owns the 1-bit priority pointer
// and registers ptr_next_o, which hands priority to the loser after each grant.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       winner_o,
  output logic       ptr_next_o
);

  // Grant decode and pointer advance.
  always_comb begin
    gnt_o      = 2'b00;
    winner_o   = 1'b0;
    ptr_next_o = ptr_i;
    case (req_i)
      2'b01: begin
        gnt_o    = 2'b01;
        winner_o = 1'b0;
      end
      2'b10: begin
        gnt_o    = 2'b10;
        winner_o = 1'b1;
      end
      2'b11: begin
        gnt_o    = ptr_i ? 2'b10 : 2'b01;
        winner_o = ptr_i;
      end
      default: begin
        gnt_o    = 2'b00;
        winner_o = 1'b0;
      end
    endcase
    if (update_i && (req_i != 2'b00)) begin
      ptr_next_o = ~winner_o;
    end else begin
      ptr_next_o = ptr_i;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Serializes two requesters onto the single register-file port: IDLE -> ACCESS -> RESP.
// Every output is a register, so REQ never reaches GNT combinationally.
module reg_file_arbiter
  import reg_file_arb_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTN,
  reg_file_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]   RF_ADDR,
  output logic [NUM_REGS-1:0] RF_CE,
  output logic [DATA_W-1:0]   RF_DATA_IN,
  input  logic [DATA_W-1:0]   RF_DATA_OUT
);

  state_e               state_q;
  logic                 ptr_q;
  logic                 ptr_d;
  logic                 cmd_id_q;
  logic                 cmd_we_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [NUM_PORTS-1:0] done_q;
  logic                 busy_q;
  logic [DATA_W-1:0]    rdata0_q;
  logic [DATA_W-1:0]    rdata1_q;
  logic [ADDR_W-1:0]    rf_addr_q;
  logic [NUM_REGS-1:0]  rf_ce_q;
  logic [DATA_W-1:0]    rf_din_q;

  logic [1:0]           arb_gnt_s;
  logic                 winner_s;
  logic                 win_we_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic [DATA_W-1:0]    win_wdata_s;

  rr_arbiter2 u_arb (
    .req_i      (bus.REQ),
    .update_i   (state_q == IDLE),
    .ptr_i      (ptr_q),
    .gnt_o      (arb_gnt_s),
    .winner_o   (winner_s),
    .ptr_next_o (ptr_d)
  );

  assign win_we_s    = winner_s ? bus.WE[1] : bus.WE[0];
  assign win_addr_s  = winner_s ? bus.ADDR1 : bus.ADDR0;
  assign win_wdata_s = winner_s ? bus.WDATA1 : bus.WDATA0;

  // Sequencer FSM with command, RF-drive and response registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      cmd_id_q  <= 1'b0;
      cmd_we_q  <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      rdata0_q  <= {DATA_W{1'b0}};
      rdata1_q  <= {DATA_W{1'b0}};
      rf_addr_q <= {ADDR_W{1'b0}};
      rf_ce_q   <= {NUM_REGS{1'b0}};
      rf_din_q  <= {DATA_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          if (bus.REQ != 2'b00) begin
            state_q   <= ACCESS;
            cmd_id_q  <= winner_s;
            cmd_we_q  <= win_we_s;
            gnt_q     <= arb_gnt_s;
            busy_q    <= 1'b1;
            rf_addr_q <= win_addr_s;
            rf_din_q  <= win_wdata_s;
            rf_ce_q   <= win_we_s ? onehot_addr(win_addr_s) : {NUM_REGS{1'b0}};
          end else begin
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            rf_ce_q <= {NUM_REGS{1'b0}};
          end
        end
        ACCESS: begin
          state_q <= RESP;
          gnt_q   <= 2'b00;
          rf_ce_q <= {NUM_REGS{1'b0}};
          busy_q  <= 1'b1;
        end
        RESP: begin
          // RF_DATA_OUT now reflects the address driven during ACCESS.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= cmd_id_q ? 2'b10 : 2'b01;
          if (!cmd_we_q && cmd_id_q) begin
            rdata1_q <= RF_DATA_OUT;
          end else if (!cmd_we_q) begin
            rdata0_q <= RF_DATA_OUT;
          end else begin
            rdata0_q <= rdata0_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          rf_ce_q <= {NUM_REGS{1'b0}};
        end
      endcase
    end
  end

  assign bus.GNT    = gnt_q;
  assign bus.DONE   = done_q;
  assign bus.BUSY   = busy_q;
  assign bus.RDATA0 = rdata0_q;
  assign bus.RDATA1 = rdata1_q;
  assign RF_ADDR    = rf_addr_q;
  assign RF_CE      = rf_ce_q;
  assign RF_DATA_IN = rf_din_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural 4 x 8 register file
// (registered read, pre-write data) attached to the RF port.
module tb_reg_file_arbiter;
  import reg_file_arb_pkg::*;

  logic                CLK;
  logic                RSTN;
  logic [ADDR_W-1:0]   RF_ADDR;
  logic [NUM_REGS-1:0] RF_CE;
  logic [DATA_W-1:0]   RF_DATA_IN;
  logic [DATA_W-1:0]   RF_DATA_OUT;
  logic [DATA_W-1:0]   rf_mem [NUM_REGS];

  int vectors;
  int miscompares;

  reg_file_arbiter_if bus ();

  reg_file_arbiter dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .bus         (bus),
    .RF_ADDR     (RF_ADDR),
    .RF_CE       (RF_CE),
    .RF_DATA_IN  (RF_DATA_IN),
    .RF_DATA_OUT (RF_DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: per-register write enable, one-cycle registered read.
  always @(posedge CLK) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RF_CE[i]) rf_mem[i] <= RF_DATA_IN;
    end
    RF_DATA_OUT <= rf_mem[RF_ADDR];
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gnt"},   32'(bus.GNT),    32'h0);
    chk({pfx, "_done"},  32'(bus.DONE),   32'h0);
    chk({pfx, "_busy"},  32'(bus.BUSY),   32'h0);
    chk({pfx, "_ce"},    32'(RF_CE),      32'h0);
    chk({pfx, "_addr"},  32'(RF_ADDR),    32'h0);
    chk({pfx, "_din"},   32'(RF_DATA_IN), 32'h0);
    chk({pfx, "_rd0"},   32'(bus.RDATA0), 32'h0);
    chk({pfx, "_rd1"},   32'(bus.RDATA1), 32'h0);
  endtask

  // Single-port transaction starting in an IDLE cycle (cycle 0); ends in its DONE cycle.
  task automatic txn(input string tag, input int p, input logic we, input logic [1:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd);
    logic [1:0] pbit;
    logic [3:0] ce_exp;
    pbit   = (p == 1) ? 2'b10 : 2'b01;
    ce_exp = we ? (4'b0001 << a) : 4'b0000;
    bus.REQ[p] = 1'b1;
    bus.WE[p]  = we;
    if (p == 1) begin
      bus.ADDR1 = a; bus.WDATA1 = d;
    end else begin
      bus.ADDR0 = a; bus.WDATA0 = d;
    end
    step();
    chk({tag, "_c1_gnt"},  32'(bus.GNT),  32'(pbit));
    chk({tag, "_c1_ce"},   32'(RF_CE),    32'(ce_exp));
    chk({tag, "_c1_busy"}, 32'(bus.BUSY), 32'h1);
    chk({tag, "_c1_addr"}, 32'(RF_ADDR),  32'(a));
    if (we) chk({tag, "_c1_din"}, 32'(RF_DATA_IN), 32'(d));
    bus.REQ[p] = 1'b0;
    step();
    chk({tag, "_c2_gnt"},  32'(bus.GNT),  32'h0);
    chk({tag, "_c2_ce"},   32'(RF_CE),    32'h0);
    chk({tag, "_c2_busy"}, 32'(bus.BUSY), 32'h1);
    chk({tag, "_c2_done"}, 32'(bus.DONE), 32'h0);
    step();
    chk({tag, "_c3_done"}, 32'(bus.DONE), 32'(pbit));
    chk({tag, "_c3_busy"}, 32'(bus.BUSY), 32'h0);
    chk({tag, "_c3_ce"},   32'(RF_CE),    32'h0);
    if (!we) chk({tag, "_c3_rdata"}, 32'((p == 1) ? bus.RDATA1 : bus.RDATA0), 32'(exp_rd));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 8'h00;
    RF_DATA_OUT = 8'h00;
    RSTN        = 1'b0;
    bus.REQ     = 2'b00;
    bus.WE      = 2'b00;
    bus.ADDR0   = 2'd0;
    bus.ADDR1   = 2'd0;
    bus.WDATA0  = 8'h00;
    bus.WDATA1  = 8'h00;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    RSTN = 1'b1;
    step();

    // Port 0 writes A5 to address 2, then port 1 reads it back
    txn("p0_wr_a5", 0, 1'b1, 2'd2, 8'hA5, 8'h00);
    txn("p1_rd_a5", 1, 1'b0, 2'd2, 8'h00, 8'hA5);

    // Both ports request continuously: grants alternate 0,1,0,1
    bus.REQ = 2'b11; bus.WE = 2'b01;
    bus.ADDR0 = 2'd1; bus.WDATA0 = 8'h11;
    bus.ADDR1 = 2'd1; bus.WDATA1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", 32'(bus.GNT), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_ce",  32'(RF_CE),   (k % 2 == 0) ? 32'h2 : 32'h0);
      step();
      chk("rr_resp_gnt", 32'(bus.GNT), 32'h0);
      step();
      chk("rr_done", 32'(bus.DONE), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k % 2 == 1) chk("rr_rd1", 32'(bus.RDATA1), 32'h11);
      if (k == 3) bus.REQ = 2'b00;
    end

    // Same port: write then read back-to-back, new REQ taken in the DONE cycle
    txn("b2b_wr", 0, 1'b1, 2'd3, 8'h3C, 8'h00);
    txn("b2b_rd", 0, 1'b0, 2'd3, 8'h00, 8'h3C);
    chk("rd1_held", 32'(bus.RDATA1), 32'h11);

    // Reset asserted during ACCESS of a write by port 1
    bus.REQ[1] = 1'b1; bus.WE[1] = 1'b1; bus.ADDR1 = 2'd0; bus.WDATA1 = 8'h77;
    step();
    chk("abort_gnt", 32'(bus.GNT), 32'h2);
    chk("abort_ce",  32'(RF_CE),   32'h1);
    #1;
    RSTN = 1'b0;
    bus.REQ = 2'b00;
    #1;
    chk_all_zero("abort");
    step();
    chk("abort_hold_done", 32'(bus.DONE), 32'h0);
    RSTN = 1'b1;
    step();
    chk("abort_post_done", 32'(bus.DONE), 32'h0);
    chk("abort_post_busy", 32'(bus.BUSY), 32'h0);
    step();
    chk("abort_post_done2", 32'(bus.DONE), 32'h0);
    txn("abort_nowrite", 0, 1'b0, 2'd0, 8'h00, 8'h00);

    // REQ[1] raised during port 0's RESP is held off until IDLE
    bus.REQ[0] = 1'b1; bus.WE[0] = 1'b0; bus.ADDR0 = 2'd2;
    step();
    chk("late_c1_gnt", 32'(bus.GNT), 32'h1);
    bus.REQ[0] = 1'b0;
    step();
    bus.REQ[1] = 1'b1; bus.WE[1] = 1'b0; bus.ADDR1 = 2'd1;
    chk("late_c2_gnt", 32'(bus.GNT), 32'h0);
    step();
    chk("late_c3_gnt",  32'(bus.GNT),    32'h0);
    chk("late_c3_done", 32'(bus.DONE),   32'h1);
    chk("late_c3_rd0",  32'(bus.RDATA0), 32'hA5);
    step();
    chk("late_c4_gnt", 32'(bus.GNT), 32'h2);
    bus.REQ[1] = 1'b0;
    step();
    chk("late_c5_gnt", 32'(bus.GNT), 32'h0);
    step();
    chk("late_c6_gnt",  32'(bus.GNT),    32'h0);
    chk("late_c6_done", 32'(bus.DONE),   32'h2);
    chk("late_c6_rd1",  32'(bus.RDATA1), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
